ica_display_regs: RTL

- Display register file and CLUT directly downstream of the two ICA/DCA control channels (plane A, plane B).
- Consumes their register-write strobes and arbitrates them onto one commit path.
- Holds the display control registers and the shared 256-entry 24-bit CLUT.
- Provides two 1-cycle-latency CLUT lookup ports to the pixel pipeline.

---
 rtl/ica_display_regs.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ica_display_regs.sv
// Display control register file and shared CLUT for the two ICA/DCA channels.
// Writes from plane A and plane B share one commit path; plane A has priority.
module ica_display_regs #(
  parameter int CLUT_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  wr_adr_a,
  input  logic [23:0] wr_data_a,
  input  logic        wr_a,
  input  logic [6:0]  wr_adr_b,
  input  logic [23:0] wr_data_b,
  input  logic        wr_b,
  input  logic [7:0]  idx_a,
  output logic [23:0] rgb_a,
  input  logic [7:0]  idx_b,
  output logic [23:0] rgb_b,
  output logic [3:0]  coding_a,
  output logic [3:0]  coding_b,
  output logic [3:0]  trans_a,
  output logic [3:0]  trans_b,
  output logic        plane_order,
  output logic [1:0]  clut_bank,
  output logic [3:0]  backdrop,
  output logic [23:0] tcol_a,
  output logic [23:0] tcol_b,
  output logic        overflow,
  output logic        busy
);

  typedef struct packed {
    logic [6:0]  adr;
    logic [23:0] data;
  } wr_t;

  wr_t  new_a, new_b, slot_a, slot_b, cand_a, cand_b, commit;
  logic slot_a_v, slot_b_v;
  logic cand_a_v, cand_b_v, commit_a, commit_b, commit_v;
  logic park_a, park_b, accept_a, accept_b, drop;
  logic clut_we;
  logic [7:0] clut_wa;
  logic [23:0] clut [CLUT_DEPTH];

  assign new_a = '{adr: wr_adr_a, data: wr_data_a};
  assign new_b = '{adr: wr_adr_b, data: wr_data_b};

  // A parked write always drains before a newer write of the same channel,
  // which keeps per-channel order intact.
  always_comb begin
    cand_a_v = slot_a_v | wr_a;
    cand_b_v = slot_b_v | wr_b;
    cand_a   = slot_a_v ? slot_a : new_a;
    cand_b   = slot_b_v ? slot_b : new_b;
    commit_a = cand_a_v;
    commit_b = cand_b_v & ~cand_a_v;
    commit_v = commit_a | commit_b;
    commit   = commit_a ? cand_a : cand_b;
    // A new write parks unless it is itself the committing candidate.
    park_a   = wr_a & ~(commit_a & ~slot_a_v);
    park_b   = wr_b & ~(commit_b & ~slot_b_v);
    accept_a = park_a & (~slot_a_v | commit_a);
    accept_b = park_b & (~slot_b_v | commit_b);
    drop     = (park_a & ~accept_a) | (park_b & ~accept_b);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_a_v <= 1'b0;
      slot_b_v <= 1'b0;
      overflow <= 1'b0;
    end else begin
      slot_a_v <= accept_a | (slot_a_v & ~commit_a);
      slot_b_v <= accept_b | (slot_b_v & ~commit_b);
      overflow <= overflow | drop;
      if (accept_a) slot_a <= new_a;
      if (accept_b) slot_b <= new_b;
    end
  end

  assign busy = slot_a_v | slot_b_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      coding_a    <= '0;
      coding_b    <= '0;
      trans_a     <= '0;
      trans_b     <= '0;
      plane_order <= 1'b0;
      clut_bank   <= '0;
      backdrop    <= '0;
      tcol_a      <= '0;
      tcol_b      <= '0;
    end else if (commit_v) begin
      case (commit.adr)
        7'h40: begin coding_a <= commit.data[3:0]; coding_b <= commit.data[11:8]; end
        7'h41: begin trans_a  <= commit.data[3:0]; trans_b  <= commit.data[11:8]; end
        7'h42: plane_order <= commit.data[0];
        7'h43: clut_bank   <= commit.data[1:0];
        7'h44: tcol_a      <= commit.data;
        7'h46: tcol_b      <= commit.data;
        7'h58: backdrop    <= commit.data[3:0];
        default: ;
      endcase
    end
  end

  // The CLUT index uses the bank register as it stood before this commit.
  assign clut_we = commit_v & ~commit.adr[6] & ~reset;
  assign clut_wa = {clut_bank, commit.adr[5:0]};

  // NOTE: the CLUT array has no reset so it can map onto RAM; only the read registers are cleared.
  always_ff @(posedge clk) begin
    if (clut_we) clut[clut_wa] <= commit.data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_a <= '0;
      rgb_b <= '0;
    end else begin
      rgb_a <= clut[idx_a];
      rgb_b <= clut[idx_b];
    end
  end

endmodule
